// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Merges the pipeline's fixed-slot writeback with long-latency multiply/divide
//   results, which are buffered in a small FIFO. Drives one registered write
//   per cycle into the register file's single write port. Also keeps a
//   scoreboard of destinations whose long-op result is still outstanding.
//
// Ports
//   clk_i             rising-edge clock
//   rst_ni            asynchronous active-low reset, clears all state
//   pipe_wr_i         pipeline WB write strobe (slot is idle when pipe_addr_i is 0)
//   pipe_addr_i       pipeline destination register
//   pipe_data_i       pipeline write data
//   lop_valid_i       long-op result valid
//   lop_ready_o       result FIFO not full
//   lop_addr_i        long-op destination (0: accepted, then dropped)
//   lop_data_i        long-op result
//   lop_issue_i       long-op dispatched by decode this cycle
//   lop_issue_addr_i  destination of the dispatched long-op
//   rf_wr_o           register file write enable (registered)
//   rf_addr_o         register file write address (registered, held when idle)
//   rf_data_o         register file write data (registered, held when idle)
//   busy_o            pending long-op destinations; bit 0 is always 0
//   wb_hold_o         asks the hazard unit to keep the pipeline slot idle
module wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pipe_wr_i,
  input  logic [4:0]  pipe_addr_i,
  input  logic [31:0] pipe_data_i,
  input  logic        lop_valid_i,
  output logic        lop_ready_o,
  input  logic [4:0]  lop_addr_i,
  input  logic [31:0] lop_data_i,
  input  logic        lop_issue_i,
  input  logic [4:0]  lop_issue_addr_i,
  output logic        rf_wr_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_data_o,
  output logic [31:0] busy_o,
  output logic        wb_hold_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic [31:0]   busy_q, busy_d;
  logic          rf_wr_q, rf_wr_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic pipe_valid, fifo_empty, fifo_full, push, pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign pipe_valid = pipe_wr_i && (pipe_addr_i != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign head_addr  = addr_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];

  // Ready depends only on the registered count, so a pop in the same cycle
  // never opens a slot for a full FIFO.
  assign lop_ready_o = !fifo_full;
  // Results for $0 complete the handshake but are never stored.
  assign push = lop_valid_i && !fifo_full && (lop_addr_i != 5'd0);
  assign pop  = !pipe_valid && !fifo_empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    starve_d  = starve_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (pipe_valid) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = pipe_addr_i;
      rf_data_d = pipe_data_i;
    end else if (pop) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = head_addr;
      rf_data_d = head_data;
    end

    // Clear first so a same-edge issue to the same register wins.
    if (pop) busy_d[head_addr] = 1'b0;
    if (lop_issue_i && (lop_issue_addr_i != 5'd0)) busy_d[lop_issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;

    // Saturating count of cycles the queued head lost to the pipeline.
    if (pop || fifo_empty) starve_d = '0;
    else if (pipe_valid && (starve_q != CW'(STARVE_LIMIT))) starve_d = starve_q + 1'b1;

    if (pop) hold_d = 1'b0;
    else if (starve_d == CW'(STARVE_LIMIT)) hold_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      hold_q    <= 1'b0;
      busy_q    <= '0;
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= lop_addr_i;
      data_mem_q[wr_ptr_q] <= lop_data_i;
    end
  end

  assign rf_wr_o   = rf_wr_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;
  assign busy_o    = busy_q;
  assign wb_hold_o = hold_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk, rst_n;
  logic        pipe_wr;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lop_valid, lop_ready;
  logic [4:0]  lop_addr;
  logic [31:0] lop_data;
  logic        lop_issue;
  logic [4:0]  lop_issue_addr;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy;
  logic        wb_hold;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pipe_wr_i(pipe_wr), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .lop_valid_i(lop_valid), .lop_ready_o(lop_ready),
    .lop_addr_i(lop_addr), .lop_data_i(lop_data),
    .lop_issue_i(lop_issue), .lop_issue_addr_i(lop_issue_addr),
    .rf_wr_o(rf_wr), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .busy_o(busy), .wb_hold_o(wb_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the falling edge, well away from the rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    pipe_wr   = 1'b1;
    pipe_addr = a;
    pipe_data = d;
    if (a != 5'd0) begin
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_lop(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Write monitor: each entry pushed during a selection cycle must appear on
  // rf_* at the next falling edge; with nothing expected the port must be idle.
  always @(negedge clk) begin
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_wr", {31'd0, rf_wr}, 32'd1);
      chk("rf_addr", {27'd0, rf_addr}, {27'd0, e.a});
      chk("rf_data", rf_data, e.d);
    end else begin
      chk("rf_idle", {31'd0, rf_wr}, 32'd0);
    end
  end

  // Protocol: the pipeline must keep its slot idle while wb_hold is high.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(wb_hold && pipe_wr && (pipe_addr != 5'd0))) else begin
        errors++;
        $error("FAIL hold_protocol observed pipe write to %0d expected none", pipe_addr);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    pipe_wr = 1'b0; pipe_addr = '0; pipe_data = '0;
    lop_valid = 1'b0; lop_addr = '0; lop_data = '0;
    lop_issue = 1'b0; lop_issue_addr = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rf_wr", {31'd0, rf_wr}, 32'd0);
    chk("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ready", {31'd0, lop_ready}, 32'd1);
    chk("rst_hold", {31'd0, wb_hold}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Pipeline only, then a write to $0 which is an idle slot.
    pipe(5'd5, 32'hDEADBEEF);
    tick();
    pipe(5'd0, 32'h11111111);
    tick();
    pipe_wr = 1'b0;
    tick();
    chk("hold_addr", {27'd0, rf_addr}, 32'd5);
    chk("hold_data", rf_data, 32'hDEADBEEF);

    // Long-op with an idle pipeline.
    lop_issue = 1'b1; lop_issue_addr = 5'd9;
    tick();
    lop_issue = 1'b0;
    chk("busy_set9", busy, 32'h0000_0200);
    lop_valid = 1'b1; lop_addr = 5'd9; lop_data = 32'h12345678;
    tick();
    lop_valid = 1'b0;
    chk("busy9_pending", busy, 32'h0000_0200);
    expect_lop(5'd9, 32'h12345678);
    tick();
    chk("busy9_clear", busy, 32'd0);

    // Contention: pipeline writes every cycle while regs 3 and 4 queue up.
    lop_issue = 1'b1; lop_issue_addr = 5'd3;
    pipe(5'd10, 32'hA000_0010);
    lop_valid = 1'b1; lop_addr = 5'd3; lop_data = 32'h0000_0333;
    chk("ready_empty", {31'd0, lop_ready}, 32'd1);
    tick();
    lop_issue_addr = 5'd4;
    pipe(5'd11, 32'hA000_0011);
    lop_addr = 5'd4; lop_data = 32'h0000_0444;
    chk("ready_one", {31'd0, lop_ready}, 32'd1);
    tick();
    lop_issue = 1'b0;
    lop_valid = 1'b0;
    pipe(5'd12, 32'hA000_0012);
    chk("ready_full", {31'd0, lop_ready}, 32'd0);
    chk("busy_34", busy, 32'h0000_0018);
    tick();
    pipe(5'd13, 32'hA000_0013);
    chk("ready_full2", {31'd0, lop_ready}, 32'd0);
    tick();
    chk("hold_low_c", {31'd0, wb_hold}, 32'd0);
    pipe_wr = 1'b0;
    expect_lop(5'd3, 32'h0000_0333);
    tick();
    expect_lop(5'd4, 32'h0000_0444);
    chk("ready_after_pop", {31'd0, lop_ready}, 32'd1);
    chk("busy_4", busy, 32'h0000_0010);
    tick();
    chk("busy_drained", busy, 32'd0);

    // Starvation: one queued entry, four consecutive pipeline wins.
    lop_valid = 1'b1; lop_addr = 5'd20; lop_data = 32'h5555_AAAA;
    tick();
    lop_valid = 1'b0;
    pipe(5'd21, 32'hB000_0021);
    tick();
    pipe(5'd22, 32'hB000_0022);
    tick();
    pipe(5'd23, 32'hB000_0023);
    tick();
    pipe(5'd24, 32'hB000_0024);
    chk("hold_3rd", {31'd0, wb_hold}, 32'd0);
    tick();
    chk("hold_4th", {31'd0, wb_hold}, 32'd1);
    pipe_wr = 1'b0;
    expect_lop(5'd20, 32'h5555_AAAA);
    tick();
    chk("hold_release", {31'd0, wb_hold}, 32'd0);

    // Scoreboard collision: pop of 7 and a new issue to 7 at one edge.
    lop_issue = 1'b1; lop_issue_addr = 5'd7;
    lop_valid = 1'b1; lop_addr = 5'd7; lop_data = 32'h0000_C007;
    tick();
    lop_valid = 1'b0;
    chk("busy7_set", busy, 32'h0000_0080);
    expect_lop(5'd7, 32'h0000_C007);
    tick();
    chk("busy7_collide", busy, 32'h0000_0080);
    lop_issue_addr = 5'd0;
    tick();
    lop_issue = 1'b0;
    chk("busy_r0", busy, 32'h0000_0080);
    lop_valid = 1'b1; lop_addr = 5'd7; lop_data = 32'h0000_C008;
    tick();
    lop_valid = 1'b0;
    expect_lop(5'd7, 32'h0000_C008);
    tick();
    chk("busy7_clear", busy, 32'd0);
    // Result for $0: handshake completes, nothing is written.
    lop_valid = 1'b1; lop_addr = 5'd0; lop_data = 32'hFFFF_FFFF;
    tick();
    lop_valid = 1'b0;
    tick();
    chk("ready_r0", {31'd0, lop_ready}, 32'd1);

    // Async reset with two queued entries and busy = 0x180.
    lop_issue = 1'b1; lop_issue_addr = 5'd7;
    lop_valid = 1'b1; lop_addr = 5'd7; lop_data = 32'h0000_0777;
    pipe(5'd1, 32'hC000_0001);
    tick();
    lop_issue_addr = 5'd8;
    lop_addr = 5'd8; lop_data = 32'h0000_0888;
    pipe(5'd2, 32'hC000_0002);
    tick();
    lop_issue = 1'b0;
    lop_valid = 1'b0;
    pipe(5'd3, 32'hC000_0003);
    chk("busy_180", busy, 32'h0000_0180);
    chk("ready_full3", {31'd0, lop_ready}, 32'd0);
    tick();
    pipe_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_wr", {31'd0, rf_wr}, 32'd0);
    chk("arst_rf_addr", {27'd0, rf_addr}, 32'd0);
    chk("arst_rf_data", rf_data, 32'd0);
    chk("arst_busy", busy, 32'd0);
    chk("arst_ready", {31'd0, lop_ready}, 32'd1);
    chk("arst_hold", {31'd0, wb_hold}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("post_busy", busy, 32'd0);
    chk("post_ready", {31'd0, lop_ready}, 32'd1);
    chk("exp_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
